// File: rtl/hash_2_bucket.sv
// hash_2_bucket: 1024-row x 2-bucket MAC learn/search table with aging sweep.
// Entry layout: {age[9:0], mac[47:0], portmap[15:0]}. An entry is valid when age != 0.
// Optional feature macro: HASH_2_BUCKET_REFRESH_ON_HIT_EN. When it is defined, a search
// hit rewrites that entry's age to AGE_INIT in one extra cycle before the response.
module hash_2_bucket #(
    parameter logic [9:0] AGE_INIT = 10'd300
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        se_source,
    input  logic [47:0] se_mac,
    input  logic [15:0] se_portmap,
    input  logic [9:0]  se_hash,
    input  logic        se_req,
    output logic        se_ack,
    output logic        se_nak,
    output logic [15:0] se_result,
    input  logic        aging_req,
    output logic        aging_ack
);

    typedef enum logic [3:0] {
        S_CLEAR, S_IDLE, S_RD, S_CMP, S_REFR, S_RESP, S_AG_RD, S_AG_CMP, S_AG_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  clr_cnt_reg, clr_cnt_next;
    logic [9:0]  ag_cnt_reg, ag_cnt_next;
    logic        src_reg, src_next;
    logic [47:0] mac_reg, mac_next;
    logic [15:0] pm_reg, pm_next;
    logic [9:0]  hash_reg, hash_next;
    logic        se_ack_reg, se_ack_next;
    logic        se_nak_reg, se_nak_next;
    logic [15:0] se_result_reg, se_result_next;
    logic        aging_ack_reg, aging_ack_next;
`ifdef HASH_2_BUCKET_REFRESH_ON_HIT_EN
    logic        hit_sel_reg, hit_sel_next;
    logic [15:0] hit_pm_reg, hit_pm_next;
`endif

    // RAM port signals shared by both buckets
    logic [9:0]       rd_addr;
    logic [9:0]       wr_addr;
    logic [1:0]       wr_en;
    logic [1:0][73:0] wr_data;
    logic [1:0][9:0]  rd_age;
    logic [1:0][47:0] rd_mac;
    logic [1:0][15:0] rd_pm;

    // Row-level compare results used while in S_CMP
    logic [1:0] valid;
    logic [1:0] hit;
    logic [73:0] learn_entry;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bucket
            logic [73:0] mem [0:1023];
            logic [73:0] q_reg;

            // One block RAM per bucket: synchronous write, registered read
            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    mem[wr_addr] <= wr_data[gi];
                end
                q_reg <= mem[rd_addr];
            end

            assign rd_age[gi] = q_reg[73:64];
            assign rd_mac[gi] = q_reg[63:16];
            assign rd_pm[gi]  = q_reg[15:0];
            assign valid[gi]  = (rd_age[gi] != 10'd0);
            assign hit[gi]    = valid[gi] && (rd_mac[gi] == mac_reg);
        end
    endgenerate

    assign learn_entry = {AGE_INIT, mac_reg, pm_reg};

    // State and request/response registers; reset restarts the table clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= S_CLEAR;
            clr_cnt_reg   <= 10'd0;
            ag_cnt_reg    <= 10'd0;
            src_reg       <= 1'b0;
            mac_reg       <= 48'd0;
            pm_reg        <= 16'd0;
            hash_reg      <= 10'd0;
            se_ack_reg    <= 1'b0;
            se_nak_reg    <= 1'b0;
            se_result_reg <= 16'd0;
            aging_ack_reg <= 1'b0;
`ifdef HASH_2_BUCKET_REFRESH_ON_HIT_EN
            hit_sel_reg   <= 1'b0;
            hit_pm_reg    <= 16'd0;
`endif
        end else begin
            state_reg     <= state_next;
            clr_cnt_reg   <= clr_cnt_next;
            ag_cnt_reg    <= ag_cnt_next;
            src_reg       <= src_next;
            mac_reg       <= mac_next;
            pm_reg        <= pm_next;
            hash_reg      <= hash_next;
            se_ack_reg    <= se_ack_next;
            se_nak_reg    <= se_nak_next;
            se_result_reg <= se_result_next;
            aging_ack_reg <= aging_ack_next;
`ifdef HASH_2_BUCKET_REFRESH_ON_HIT_EN
            hit_sel_reg   <= hit_sel_next;
            hit_pm_reg    <= hit_pm_next;
`endif
        end
    end

    // Next-state, RAM control and response logic
    always_comb begin
        state_next     = state_reg;
        clr_cnt_next   = clr_cnt_reg;
        ag_cnt_next    = ag_cnt_reg;
        src_next       = src_reg;
        mac_next       = mac_reg;
        pm_next        = pm_reg;
        hash_next      = hash_reg;
        se_ack_next    = se_ack_reg;
        se_nak_next    = se_nak_reg;
        se_result_next = se_result_reg;
        aging_ack_next = aging_ack_reg;
`ifdef HASH_2_BUCKET_REFRESH_ON_HIT_EN
        hit_sel_next   = hit_sel_reg;
        hit_pm_next    = hit_pm_reg;
`endif
        rd_addr = hash_reg;
        wr_addr = hash_reg;
        wr_en   = 2'b00;
        wr_data = '0;

        case (state_reg)
            S_CLEAR: begin
                wr_en        = 2'b11;
                wr_addr      = clr_cnt_reg;
                clr_cnt_next = clr_cnt_reg + 10'd1;
                if (clr_cnt_reg == 10'd1023) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                // Search/learn wins over aging when both are pending
                if (se_req) begin
                    src_next   = se_source;
                    mac_next   = se_mac;
                    pm_next    = se_portmap;
                    hash_next  = se_hash;
                    state_next = S_RD;
                end else if (aging_req) begin
                    ag_cnt_next = 10'd0;
                    state_next  = S_AG_RD;
                end
            end
            S_RD: begin
                rd_addr    = hash_reg;
                state_next = S_CMP;
            end
            S_CMP: begin
                state_next = S_RESP;
                if (!src_reg) begin
                    if (hit != 2'b00) begin
`ifdef HASH_2_BUCKET_REFRESH_ON_HIT_EN
                        hit_sel_next = !hit[0];
                        hit_pm_next  = hit[0] ? rd_pm[0] : rd_pm[1];
                        state_next   = S_REFR;
`else
                        se_ack_next    = 1'b1;
                        se_result_next = hit[0] ? rd_pm[0] : rd_pm[1];
`endif
                    end else begin
                        se_nak_next    = 1'b1;
                        se_result_next = 16'd0;
                    end
                end else begin
                    // Existing MAC is updated in place so it never sits in both buckets
                    wr_data        = {learn_entry, learn_entry};
                    se_result_next = 16'd0;
                    if (hit[0]) begin
                        wr_en = 2'b01;
                    end else if (hit[1]) begin
                        wr_en = 2'b10;
                    end else if (!valid[0]) begin
                        wr_en = 2'b01;
                    end else if (!valid[1]) begin
                        wr_en = 2'b10;
                    end
                    if (hit != 2'b00 || valid != 2'b11) begin
                        se_ack_next = 1'b1;
                    end else begin
                        se_nak_next = 1'b1;
                    end
                end
            end
`ifdef HASH_2_BUCKET_REFRESH_ON_HIT_EN
            S_REFR: begin
                wr_data        = {2{AGE_INIT, mac_reg, hit_pm_reg}};
                wr_en          = hit_sel_reg ? 2'b10 : 2'b01;
                se_ack_next    = 1'b1;
                se_result_next = hit_pm_reg;
                state_next     = S_RESP;
            end
`endif
            S_RESP: begin
                if (!se_req) begin
                    se_ack_next    = 1'b0;
                    se_nak_next    = 1'b0;
                    se_result_next = 16'd0;
                    state_next     = S_IDLE;
                end
            end
            S_AG_RD: begin
                rd_addr    = ag_cnt_reg;
                state_next = S_AG_CMP;
            end
            S_AG_CMP: begin
                // Decrement each valid entry; an age of 0 stays 0
                wr_addr = ag_cnt_reg;
                wr_en   = 2'b11;
                for (int b = 0; b < 2; b++) begin
                    wr_data[b] = {(valid[b] ? rd_age[b] - 10'd1 : 10'd0), rd_mac[b], rd_pm[b]};
                end
                ag_cnt_next = ag_cnt_reg + 10'd1;
                if (ag_cnt_reg == 10'd1023) begin
                    aging_ack_next = 1'b1;
                    state_next     = S_AG_DONE;
                end else begin
                    state_next = S_AG_RD;
                end
            end
            S_AG_DONE: begin
                if (!aging_req) begin
                    aging_ack_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next = S_CLEAR;
            end
        endcase
    end

    assign se_ack    = se_ack_reg;
    assign se_nak    = se_nak_reg;
    assign se_result = se_result_reg;
    assign aging_ack = aging_ack_reg;

endmodule

// File: tb/tb_hash_2_bucket.sv
// Directed testbench for hash_2_bucket with AGE_INIT = 3 and a 10 ns clock.
module tb_hash_2_bucket;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        se_source = 1'b0;
    logic [47:0] se_mac = '0;
    logic [15:0] se_portmap = '0;
    logic [9:0]  se_hash = '0;
    logic        se_req = 1'b0;
    logic        se_ack;
    logic        se_nak;
    logic [15:0] se_result;
    logic        aging_req = 1'b0;
    logic        aging_ack;

    int errors = 0;
    int checks = 0;

    localparam logic [47:0] MAC_E = 48'he0e1e2e3e4e5;
    localparam logic [47:0] MAC_D = 48'hd0d1d2d3d4d5;
    localparam logic [47:0] MAC_C = 48'hc0c1c2c3c4c5;
    localparam logic [47:0] MAC_B = 48'hb0b1b2b3b4b5;
    localparam logic [47:0] MAC_F = 48'hf0f1f2f3f4f5;

    hash_2_bucket #(.AGE_INIT(10'd3)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .se_source  (se_source),
        .se_mac     (se_mac),
        .se_portmap (se_portmap),
        .se_hash    (se_hash),
        .se_req     (se_req),
        .se_ack     (se_ack),
        .se_nak     (se_nak),
        .se_result  (se_result),
        .aging_req  (aging_req),
        .aging_ack  (aging_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for se_ack|se_nak, drop se_req, wait for release
    task automatic finish_se(input string tag, output logic ack, output logic nak, output logic [15:0] res);
        int n = 0;
        while (!(se_ack || se_nak) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_resp_seen"}, 64'(se_ack | se_nak), 64'd1);
        ack = se_ack;
        nak = se_nak;
        res = se_result;
        se_req = 1'b0;
        n = 0;
        while ((se_ack || se_nak) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_released"}, 64'(se_ack | se_nak | (|se_result)), 64'd0);
    endtask

    task automatic start_se(input logic src, input logic [47:0] mac, input logic [15:0] pm, input logic [9:0] hash);
        @(negedge clk);
        se_source  = src;
        se_mac     = mac;
        se_portmap = pm;
        se_hash    = hash;
        se_req     = 1'b1;
    endtask

    task automatic txn(input string tag, input logic src, input logic [47:0] mac, input logic [15:0] pm,
                       input logic [9:0] hash, input logic exp_ack, input logic [15:0] exp_res);
        logic a, k;
        logic [15:0] r;
        start_se(src, mac, pm, hash);
        finish_se(tag, a, k, r);
        $display("txn %s src=%0d hash=%0d mac=%h pm=%h -> ack=%0d nak=%0d result=%h",
                 tag, src, hash, mac, pm, a, k, r);
        check({tag, "_ack"}, 64'(a), 64'(exp_ack));
        check({tag, "_nak"}, 64'(k), 64'(!exp_ack));
        check({tag, "_result"}, 64'(r), 64'(exp_res));
    endtask

    // Wait for aging_ack, confirm it is held while aging_req stays high, then release
    task automatic finish_aging(input string tag);
        int n = 0;
        while (!aging_ack && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ack_seen"}, 64'(aging_ack), 64'd1);
        repeat (4) @(negedge clk);
        check({tag, "_ack_held"}, 64'(aging_ack), 64'd1);
        aging_req = 1'b0;
        n = 0;
        while (aging_ack && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ack_released"}, 64'(aging_ack), 64'd0);
        $display("txn %s aging sweep done", tag);
    endtask

    task automatic do_aging(input string tag);
        @(negedge clk);
        aging_req = 1'b1;
        finish_aging(tag);
    endtask

    initial begin
        logic a, k;
        logic [15:0] r;
        bit seen;

        repeat (3) @(negedge clk);
        check("reset_ack", 64'(se_ack), 64'd0);
        check("reset_nak", 64'(se_nak), 64'd0);
        check("reset_result", 64'(se_result), 64'd0);
        check("reset_aging_ack", 64'(aging_ack), 64'd0);

        // A learn raised right at reset release must wait for the table clear
        rstn = 1'b1;
        se_source = 1'b1; se_mac = MAC_E; se_portmap = 16'h0002; se_hash = 10'd100;
        se_req = 1'b1;
        seen = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (se_ack || se_nak) seen = 1'b1;
        end
        check("clear_blocks_req", 64'(seen), 64'd0);
        finish_se("learn_E", a, k, r);
        $display("txn learn_E src=1 hash=100 mac=%h pm=0002 -> ack=%0d nak=%0d result=%h", MAC_E, a, k, r);
        check("learn_E_ack", 64'(a), 64'd1);

        // Row fill and overflow
        txn("learn_D", 1'b1, MAC_D, 16'h0004, 10'd100, 1'b1, 16'h0000);
        txn("learn_C_full", 1'b1, MAC_C, 16'h0008, 10'd100, 1'b0, 16'h0000);

        // Searches
        txn("srch_E", 1'b0, MAC_E, 16'h0000, 10'd100, 1'b1, 16'h0002);
        txn("srch_D", 1'b0, MAC_D, 16'h0000, 10'd100, 1'b1, 16'h0004);
        txn("srch_C", 1'b0, MAC_C, 16'h0000, 10'd100, 1'b0, 16'h0000);
        txn("srch_E_wrong_row", 1'b0, MAC_E, 16'h0000, 10'd101, 1'b0, 16'h0000);

        // Aging: E,D 3->1; refresh E to 3; E 3->1, D 1->0 (expired)
        do_aging("age1");
        do_aging("age2");
        txn("srch_D_age1", 1'b0, MAC_D, 16'h0000, 10'd100, 1'b1, 16'h0004);
        txn("relearn_E", 1'b1, MAC_E, 16'h0002, 10'd100, 1'b1, 16'h0000);
        do_aging("age3");
        do_aging("age4");
        txn("srch_E_aged", 1'b0, MAC_E, 16'h0000, 10'd100, 1'b1, 16'h0002);
        txn("srch_D_expired", 1'b0, MAC_D, 16'h0000, 10'd100, 1'b0, 16'h0000);

        // Update existing MAC in place; freed slot then goes to C; row then full
        txn("update_E", 1'b1, MAC_E, 16'h0010, 10'd100, 1'b1, 16'h0000);
        txn("srch_E_upd", 1'b0, MAC_E, 16'h0000, 10'd100, 1'b1, 16'h0010);
        txn("learn_C_free", 1'b1, MAC_C, 16'h0008, 10'd100, 1'b1, 16'h0000);
        txn("learn_B_full", 1'b1, MAC_B, 16'h0001, 10'd100, 1'b0, 16'h0000);
        txn("srch_C", 1'b0, MAC_C, 16'h0000, 10'd100, 1'b1, 16'h0008);

        // Row boundaries
        txn("learn_F_1023", 1'b1, MAC_F, 16'h0020, 10'd1023, 1'b1, 16'h0000);
        txn("srch_F_1023", 1'b0, MAC_F, 16'h0000, 10'd1023, 1'b1, 16'h0020);
        txn("srch_F_0", 1'b0, MAC_F, 16'h0000, 10'd0, 1'b0, 16'h0000);

        // se_req and aging_req raised together: search is served first
        start_se(1'b0, MAC_E, 16'h0000, 10'd100);
        aging_req = 1'b1;
        finish_se("arb_srch", a, k, r);
        $display("txn arb_srch src=0 hash=100 mac=%h -> ack=%0d nak=%0d result=%h", MAC_E, a, k, r);
        check("arb_srch_ack", 64'(a), 64'd1);
        check("arb_srch_result", 64'(r), 64'h0010);
        check("arb_no_aging_ack_yet", 64'(aging_ack), 64'd0);
        finish_aging("arb_age");

        // Reset in the middle of a sweep
        @(negedge clk);
        aging_req = 1'b1;
        repeat (300) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_mid_sweep_aging_ack", 64'(aging_ack), 64'd0);
        aging_req = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (1100) @(negedge clk);
        txn("srch_E_after_rst", 1'b0, MAC_E, 16'h0000, 10'd100, 1'b0, 16'h0000);
        txn("srch_F_after_rst", 1'b0, MAC_F, 16'h0000, 10'd1023, 1'b0, 16'h0000);

        // Reset while an ack is being held clears it and empties the table again
        txn("learn_E_post", 1'b1, MAC_E, 16'h0040, 10'd5, 1'b1, 16'h0000);
        start_se(1'b0, MAC_E, 16'h0000, 10'd5);
        repeat (6) @(negedge clk);
        check("held_ack_before_rst", 64'(se_ack), 64'd1);
        check("held_result_before_rst", 64'(se_result), 64'h0040);
        rstn = 1'b0;
        #1;
        check("rst_clears_ack", 64'(se_ack), 64'd0);
        check("rst_clears_result", 64'(se_result), 64'd0);
        se_req = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (1100) @(negedge clk);
        txn("srch_E_cleared", 1'b0, MAC_E, 16'h0000, 10'd5, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
